// File: rtl/adc_capture.sv
// Periodic capture of three 14-bit serial ADCs (Vdc1, Vdc2, current) on a shared CS/SCLK.
// Optional two-frame averaging when ADC_CAPTURE_AVG_EN is defined.
module adc_capture #(
  parameter int CLK_DIV       = 2,
  parameter int SAMPLE_PERIOD = 100,
  parameter int WARMUP_FRAMES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        adc_cs_n,
  output logic        adc_sclk,
  input  logic        sdo_v1,
  input  logic        sdo_v2,
  input  logic        sdo_i,
  output logic [13:0] Vdc1,
  output logic [13:0] Vdc2,
  output logic [13:0] Iref,
  output logic        sync,
  output logic        valid
);

  localparam int CONV_CYCLES = 32 * CLK_DIV;

  typedef enum logic [1:0] {IDLE, CONV, UPDATE, WAIT} state_t;

  state_t      state;
  logic [15:0] period_cnt;
  logic [8:0]  conv_cnt;
  logic [3:0]  div_cnt;
  logic [7:0]  frame_cnt;
  // 14-bit shifters: the two leading frame bits are pushed out the top unexamined
  logic [13:0] shift_v1;
  logic [13:0] shift_v2;
  logic [13:0] shift_i;

  logic [13:0] cur_v1;
  logic [13:0] cur_v2;
  logic [13:0] cur_i;
  logic [13:0] new_v1;
  logic [13:0] new_v2;
  logic [13:0] new_i;

  assign cur_v1 = shift_v1;
  assign cur_v2 = shift_v2;
  assign cur_i  = {~shift_i[13], shift_i[12:0]};

`ifdef ADC_CAPTURE_AVG_EN
  logic [13:0] prev_v1;
  logic [13:0] prev_v2;
  logic [13:0] prev_i;
  logic [14:0] sum_v1;
  logic [14:0] sum_v2;
  logic [14:0] sum_i;

  always_comb begin
    sum_v1 = {1'b0, cur_v1} + {1'b0, prev_v1};
    sum_v2 = {1'b0, cur_v2} + {1'b0, prev_v2};
    sum_i  = {cur_i[13], cur_i} + {prev_i[13], prev_i};
    new_v1 = sum_v1[14:1];
    new_v2 = sum_v2[14:1];
    new_i  = sum_i[14:1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_v1 <= '0;
      prev_v2 <= '0;
      prev_i  <= '0;
    end else if (state == UPDATE) begin
      prev_v1 <= cur_v1;
      prev_v2 <= cur_v2;
      prev_i  <= cur_i;
    end
  end
`else
  assign new_v1 = cur_v1;
  assign new_v2 = cur_v2;
  assign new_i  = cur_i;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      period_cnt <= '0;
    end else if (period_cnt == 16'(SAMPLE_PERIOD - 1)) begin
      period_cnt <= '0;
    end else begin
      period_cnt <= period_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      adc_cs_n  <= 1'b1;
      adc_sclk  <= 1'b1;
      conv_cnt  <= '0;
      div_cnt   <= '0;
      frame_cnt <= '0;
      shift_v1  <= '0;
      shift_v2  <= '0;
      shift_i   <= '0;
      Vdc1      <= '0;
      Vdc2      <= '0;
      Iref      <= '0;
      sync      <= 1'b0;
      valid     <= 1'b0;
    end else begin
      valid <= 1'b0;
      case (state)
        IDLE: begin
          if (period_cnt == 16'd0) begin
            state    <= CONV;
            adc_cs_n <= 1'b0;
            adc_sclk <= 1'b0;
            conv_cnt <= '0;
            div_cnt  <= '0;
          end
        end
        CONV: begin
          conv_cnt <= conv_cnt + 9'd1;
          if (div_cnt == 4'(CLK_DIV - 1)) begin
            div_cnt  <= '0;
            adc_sclk <= ~adc_sclk;
            if (!adc_sclk) begin
              shift_v1 <= {shift_v1[12:0], sdo_v1};
              shift_v2 <= {shift_v2[12:0], sdo_v2};
              shift_i  <= {shift_i[12:0], sdo_i};
            end
          end else begin
            div_cnt <= div_cnt + 4'd1;
          end
          if (conv_cnt == 9'(CONV_CYCLES - 1)) begin
            state    <= UPDATE;
            adc_cs_n <= 1'b1;
            adc_sclk <= 1'b1;
          end
        end
        UPDATE: begin
          Vdc1  <= new_v1;
          Vdc2  <= new_v2;
          Iref  <= new_i;
          valid <= 1'b1;
          if (frame_cnt != 8'(WARMUP_FRAMES)) begin
            frame_cnt <= frame_cnt + 8'd1;
          end
          if (frame_cnt >= 8'(WARMUP_FRAMES - 1)) begin
            sync <= 1'b1;
          end
          state <= WAIT;
        end
        WAIT: begin
          // At the shortest legal period the next frame is due while still here
          if (period_cnt == 16'd0) begin
            state    <= CONV;
            adc_cs_n <= 1'b0;
            adc_sclk <= 1'b0;
            conv_cnt <= '0;
            div_cnt  <= '0;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adc_capture.sv
// Directed bench for adc_capture: a default-parameter instance fed by a serial ADC model,
// plus a CLK_DIV=1 / SAMPLE_PERIOD=34 instance for frame timing.
module tb_adc_capture;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        cs_n, sclk, sdo_v1, sdo_v2, sdo_i, sync, valid;
  logic [13:0] vdc1, vdc2, iref;
  logic        cs_f, sclk_f, sync_f, valid_f;
  logic [13:0] v1_f, v2_f, i_f;

  adc_capture dut (
    .clk(clk), .rst_n(rst_n), .adc_cs_n(cs_n), .adc_sclk(sclk),
    .sdo_v1(sdo_v1), .sdo_v2(sdo_v2), .sdo_i(sdo_i),
    .Vdc1(vdc1), .Vdc2(vdc2), .Iref(iref), .sync(sync), .valid(valid)
  );

  adc_capture #(.CLK_DIV(1), .SAMPLE_PERIOD(34), .WARMUP_FRAMES(4)) dut_fast (
    .clk(clk), .rst_n(rst_n), .adc_cs_n(cs_f), .adc_sclk(sclk_f),
    .sdo_v1(1'b1), .sdo_v2(1'b1), .sdo_i(1'b1),
    .Vdc1(v1_f), .Vdc2(v2_f), .Iref(i_f), .sync(sync_f), .valid(valid_f)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Serial ADC model: MSB first, next bit presented after each SCLK rise
  logic [15:0] w1 = '0, w2 = '0, wi = '0;
  int bit_idx = 15;
  int rises = 0, rises_f = 0;
  always @(negedge cs_n) bit_idx = 15;
  always @(posedge sclk) if (!cs_n) begin rises++; #1 bit_idx = bit_idx - 1; end
  always @(posedge sclk_f) if (!cs_f) rises_f++;
  assign sdo_v1 = (bit_idx >= 0) ? w1[bit_idx[3:0]] : 1'b0;
  assign sdo_v2 = (bit_idx >= 0) ? w2[bit_idx[3:0]] : 1'b0;
  assign sdo_i  = (bit_idx >= 0) ? wi[bit_idx[3:0]] : 1'b0;

  logic [13:0] pv1 = '0, pv2 = '0, pi = '0;

  function automatic logic [13:0] exp_u(input logic [13:0] cur, input logic [13:0] prev);
`ifdef ADC_CAPTURE_AVG_EN
    logic [14:0] s;
    s = {1'b0, cur} + {1'b0, prev};
    return s[14:1];
`else
    return cur;
`endif
  endfunction

  function automatic logic [13:0] exp_s(input logic [13:0] cur, input logic [13:0] prev);
`ifdef ADC_CAPTURE_AVG_EN
    logic [14:0] s;
    s = {cur[13], cur} + {prev[13], prev};
    return s[14:1];
`else
    return cur;
`endif
  endfunction

  int start_wait;

  // ci is the raw offset-binary code sent; ei the hand-decoded two's-complement value
  task automatic run_frame(input string tag, input logic [13:0] c1, input logic [13:0] c2,
                           input logic [13:0] ci, input logic [13:0] ei, input logic esync);
    int lat;
    logic [13:0] x1, x2, xi;
    w1 = {2'b00, c1};
    w2 = {2'b00, c2};
    wi = {2'b00, ci};
    start_wait = 0;
    while (cs_n !== 1'b0 && start_wait < 300) begin
      @(negedge clk);
      start_wait++;
    end
    rises = 0;
    lat = 1;
    while (valid !== 1'b1 && lat < 300) begin
      @(negedge clk);
      lat++;
    end
    x1 = exp_u(c1, pv1);
    x2 = exp_u(c2, pv2);
    xi = exp_s(ei, pi);
    pv1 = c1; pv2 = c2; pi = ei;
    check({tag, "_latency"}, lat, 66);
    check({tag, "_sclk_rises"}, rises, 16);
    check({tag, "_vdc1"}, vdc1, x1);
    check({tag, "_vdc2"}, vdc2, x2);
    check({tag, "_iref"}, iref, xi);
    check({tag, "_sync"}, sync, esync);
    @(negedge clk);
    check({tag, "_valid_pulse"}, valid, 0);
    repeat (10) @(negedge clk);
    check({tag, "_hold"}, {vdc1, iref}, {x1, xi});
    $display("frame %s: Vdc1=%0d Vdc2=%0d Iref=%0d sync=%0b latency=%0d", tag, vdc1, vdc2,
             $signed(iref), sync, lat);
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    check("rst_cs_n", cs_n, 1);
    check("rst_sclk", sclk, 1);
    check("rst_outputs", {vdc1, vdc2, iref}, 0);
    check("rst_valid_sync", {valid, sync}, 0);
    check("rst_fast_cs_n", cs_f, 1);

    rst_n = 1'b1;
    run_frame("f1", 14'd2785, 14'd826, 14'h2CCD, 14'd3277, 1'b0);
    check("first_edge_start", start_wait, 1);
    run_frame("f2", 14'd0, 14'h3FFF, 14'h1999, 14'h3999, 1'b0);
    run_frame("f3", 14'h3FFF, 14'd0, 14'h3999, 14'h1999, 1'b0);
    run_frame("f4", 14'd5, 14'd6, 14'h2000, 14'd0, 1'b1);
    run_frame("f5", 14'd100, 14'd200, 14'h0000, 14'h2000, 1'b1);
    for (int k = 1; k <= 10; k++)
      run_frame($sformatf("s%0d", k), 14'(k * 37), 14'(k * 500), 14'(14'h2000 + k), 14'(k), 1'b1);

    // Abort a frame partway through conversion
    n = 0;
    while (cs_n !== 1'b0 && n < 300) begin @(negedge clk); n++; end
    check("midconv_found_frame", n < 300, 1);
    repeat (19) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midconv_cs_n", cs_n, 1);
    check("midconv_sclk", sclk, 1);
    check("midconv_outputs", {vdc1, vdc2, iref}, 0);
    check("midconv_valid_sync", {valid, sync}, 0);
    pv1 = '0; pv2 = '0; pi = '0;
    @(negedge clk);
    rst_n = 1'b1;
    run_frame("r1", 14'd1000, 14'd826, 14'h1F9C, 14'h3F9C, 1'b0);
    check("restart_first_edge", start_wait, 1);
    run_frame("r2", 14'd2000, 14'd0, 14'h1F37, 14'h3F37, 1'b0);

    // Minimum-period timing on the fast instance
    n = 0;
    while (cs_f !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    n = 0;
    while (cs_f !== 1'b0 && n < 100) begin @(negedge clk); n++; end
    rises_f = 0;
    n = 0;
    while (cs_f === 1'b0 && n < 100) begin @(negedge clk); n++; end
    check("fast_cs_low_cycles", n, 32);
    check("fast_sclk_rises", rises_f, 16);
    n = 0;
    while (cs_f === 1'b1 && n < 100) begin @(negedge clk); n++; end
    check("fast_cs_high_gap", n, 2);
    check("fast_vdc1_all_ones", v1_f, 14'h3FFF);
    check("fast_iref_all_ones", i_f, 14'h1FFF);
    check("fast_sync", sync_f, 1);
    $display("fast: cs_high_gap=%0d sclk_rises=%0d", n, rises_f);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
